// File: rtl/fifo_drain_tx.sv
// Read-side controller for the result FIFO: pops one packed {data, mode, result}
// entry at a time and serializes it LSB byte first onto a valid/ready byte stream.
module fifo_drain_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_MODES  = 4,
  parameter int RES_WIDTH  = 32,
  parameter int CNT_W      = 16,
  localparam int ENTRY_W   = DATA_WIDTH + NUM_MODES + RES_WIDTH,
  localparam int NUM_BYTES = (ENTRY_W + 7) / 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               en,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  input  logic [ENTRY_W-1:0] fifo_data,
  output logic [7:0]         tx_byte,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic               busy,
  output logic [CNT_W-1:0]   sent_cnt
);

  localparam int SHIFT_W = NUM_BYTES * 8;
  localparam int IDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CAPT,
    SEND
  } state_e;

  state_e             state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_q, rd_d;
  logic               valid_q, valid_d;
  logic [7:0]         byte_q, byte_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  // Every output is computed here for the next cycle, so tx_ready only ever
  // reaches the outputs through a register.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rd_d    = 1'b0;
    valid_d = 1'b0;
    byte_d  = byte_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (en && !fifo_empty) begin
          state_d = REQ;
          rd_d    = 1'b1;
        end
      end

      REQ: begin
        state_d = CAPT;
      end

      CAPT: begin
        shift_d = SHIFT_W'(fifo_data);
        idx_d   = '0;
        state_d = SEND;
        valid_d = 1'b1;
        byte_d  = shift_d[7:0];
        last_d  = (NUM_BYTES == 1);
      end

      SEND: begin
        valid_d = 1'b1;
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 8;
            byte_d  = shift_d[7:0];
            last_d  = (idx_d == LAST_IDX);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign fifo_rd  = rd_q;
  assign tx_valid = valid_q;
  assign tx_byte  = byte_q;
  assign tx_last  = last_q;
  assign busy     = busy_q;
  assign sent_cnt = cnt_q;

endmodule
